// File: rtl/orpheus_pkg.sv
// orpheus_pkg: shared FSM states, widths and result sign extension for the sine voice scheduler
package orpheus_pkg;
   localparam int CORDIC_W = 17;
   localparam int ANGLE_W  = 16;
   localparam int SINE_W   = 32;
   localparam int VOICE_W  = 3;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} sched_state_t;
   function automatic logic [SINE_W-1:0] sext_sine(input logic [CORDIC_W-1:0] v);
      return {{(SINE_W - CORDIC_W){v[CORDIC_W-1]}}, v};
   endfunction
endpackage

// File: rtl/mod_rr_arbiter.sv
// mod_rr_arbiter: grants the first set request found at or after ptr, wrapping modulo N
module mod_rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_any
);
   localparam int IW = $clog2(N);
   localparam int SW = IW + 1;
   logic [SW-1:0] sum;
   logic [IW-1:0] cand;
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      sum = '0;
      cand = '0;
      // farthest offset first, so the request nearest the pointer overwrites and wins
      for (int i = N - 1; i >= 0; i--) begin
         sum = {1'b0, ptr} + SW'(i);
         cand = sum >= SW'(N) ? IW'(sum - SW'(N)) : IW'(sum);
         if (req[cand]) begin
            gnt_idx = cand;
            gnt_any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mod_sine_scheduler.sv
// mod_sine_scheduler: shares one CORDIC among sine voices, one job in flight, round-robin grant with watchdog
module mod_sine_scheduler
   import orpheus_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic                                i_clk,
   input  logic                                i_nrst,
   input  logic [NUM_VOICES-1:0]               i_req,
   input  logic [NUM_VOICES-1:0][ANGLE_W-1:0]  i_angle,
   output logic [NUM_VOICES-1:0]               o_ack,
   output logic signed [SINE_W-1:0]            o_sine,
   output logic                                o_valid,
   output logic [VOICE_W-1:0]                  o_voice,
   output logic                                o_timeout,
   output logic signed [ANGLE_W-1:0]           o_cordic_angle,
   output logic                                o_cordic_start,
   input  logic signed [CORDIC_W-1:0]          i_cordic_sine,
   input  logic                                i_cordic_ready
);
   localparam int IW   = $clog2(NUM_VOICES);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   sched_state_t        state_q, state_d;
   logic [IW-1:0]       idx_q, ptr_q, gnt_idx;
   logic                gnt_any, timeout_hit, dlv;
   logic [ANGLE_W-1:0]  angle_q;
   logic [CORDIC_W-1:0] result_q;
   logic [WD_W-1:0]     wd_q;

   mod_rr_arbiter #(.N(NUM_VOICES)) u_arb (
      .req     (i_req),
      .ptr     (ptr_q),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_comb begin
      state_d = state_q;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE:  state_d = gnt_any ? ISSUE : IDLE;
         ISSUE: state_d = WAIT;
         WAIT: begin
            // a completion on the last watchdog cycle beats the timeout
            timeout_hit = !i_cordic_ready && wd_q == WD_W'(TIMEOUT - 1);
            state_d = (i_cordic_ready || timeout_hit) ? DELIVER : WAIT;
         end
         default: state_d = IDLE;
      endcase
      dlv = state_q == DELIVER;
      o_valid = dlv;
      o_timeout = timeout_hit;
      o_cordic_start = state_q == ISSUE;
      o_cordic_angle = (state_q == ISSUE || state_q == WAIT) ? angle_q : '0;
      o_voice = dlv ? VOICE_W'(idx_q) : '0;
      o_ack = dlv ? NUM_VOICES'(1) << idx_q : '0;
      o_sine = dlv ? sext_sine(result_q) : '0;
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         ptr_q    <= '0;
         angle_q  <= '0;
         result_q <= '0;
         wd_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && gnt_any) begin
            idx_q   <= gnt_idx;
            angle_q <= i_angle[gnt_idx];
            ptr_q   <= gnt_idx == IW'(NUM_VOICES - 1) ? '0 : gnt_idx + 1'b1;
         end
         if (state_q == ISSUE)
            wd_q <= '0;
         else if (state_q == WAIT)
            wd_q <= wd_q + 1'b1;
         if (state_q == WAIT && i_cordic_ready)
            result_q <= i_cordic_sine;
         else if (timeout_hit)
            result_q <= '0;
      end
   end
endmodule
